// File: rtl/xrisc_store_monitor_if.sv
// Store-port and log-reader bundle for xrisc_store_monitor.
// The core/reader side is master; the monitor is slave.
interface xrisc_store_monitor_if;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        log_valid;
    logic        log_ready;
    logic [31:0] log_adr;
    logic [31:0] log_data;

    modport master (
        output MemWrite, DataAdr, WriteData, log_ready,
        input  log_valid, log_adr, log_data
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, log_ready,
        output log_valid, log_adr, log_data
    );
endinterface

// File: rtl/xrisc_store_monitor.sv
// Passive store-port monitor: pass/fail verdict, timeout,
// and a log FIFO of every store evaluated while running.
module xrisc_store_monitor #(
    parameter int          DEPTH       = 8,
    parameter logic [31:0] PASS_ADR    = 32'd100,
    parameter logic [31:0] PASS_DATA   = 32'd25,
    parameter logic [31:0] SCRATCH_ADR = 32'd96,
    parameter int          TIMEOUT     = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    xrisc_store_monitor_if.slave bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timed_out,
    output logic                 overflow,
    output logic [15:0]          store_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   tmo_q, tmo_d;
    logic          to_q, to_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   scnt_q, scnt_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   mem_q [DEPTH];

    logic store, pop, full, push, expire;

    always_comb begin
        store  = (state_q == S_RUN) && bus.MemWrite;
        pop    = (cnt_q != '0) && bus.log_ready;
        full   = (cnt_q == CW'(DEPTH));
        push   = store && (!full || pop);
        expire = (state_q == S_RUN) && (TIMEOUT != 0)
               && (tmo_q >= 32'(TIMEOUT));

        state_d = state_q;
        tmo_d   = tmo_q;
        to_d    = to_q;
        ovf_d   = ovf_q;
        scnt_d  = scnt_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q + CW'(push) - CW'(pop);

        if (state_q == S_RUN)
            tmo_d = tmo_q + 32'd1;

        // A store in the expiry cycle is judged instead of timing out
        if (store) begin
            if (bus.DataAdr == PASS_ADR && bus.WriteData == PASS_DATA)
                state_d = S_PASS;
            else if (bus.DataAdr != SCRATCH_ADR)
                state_d = S_FAIL;
            if (scnt_q != 16'hFFFF)
                scnt_d = scnt_q + 16'd1;
            if (!push)
                ovf_d = 1'b1;
        end else if (expire) begin
            state_d = S_FAIL;
            to_d    = 1'b1;
        end

        if (push)
            wp_d = wp_q + 1'b1;
        if (pop)
            rp_d = rp_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            tmo_q   <= '0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            scnt_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            scnt_q  <= scnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Log storage needs no reset; occupancy gates visibility
    always_ff @(posedge clk) begin
        if (!reset && push)
            mem_q[wp_q] <= {bus.DataAdr, bus.WriteData};
    end

    assign bus.log_valid = (cnt_q != '0);
    assign bus.log_adr   = mem_q[rp_q][63:32];
    assign bus.log_data  = mem_q[rp_q][31:0];

    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign done        = pass | fail;
    assign timed_out   = to_q;
    assign overflow    = ovf_q;
    assign store_count = scnt_q;
endmodule
